// File: rtl/mux3_1.sv
// Three-input select with a zeroed illegal code, a combinational output and a
// registered copy that also flags enabled illegal selects.
module mux3_1 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  input  logic [1:0]       s,
  input  logic             en,
  output logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] y_q,
  output logic             s_err
);

  logic [WIDTH-1:0] y_q_d;
  logic             s_err_d;
  logic             s_illegal;

  assign s_illegal = (s == 2'b11);

  // Code 2'b11 drives zeros instead of passing any data input through.
  always_comb begin
    y = '0;
    unique case (s)
      2'b00:   y = d0;
      2'b01:   y = d1;
      2'b10:   y = d2;
      default: y = '0;
    endcase
  end

  always_comb begin
    y_q_d   = y_q;
    s_err_d = en & s_illegal;
    if (en) begin
      y_q_d = y;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y_q   <= '0;
      s_err <= 1'b0;
    end else begin
      y_q   <= y_q_d;
      s_err <= s_err_d;
    end
  end

endmodule

// File: tb/tb_mux3_1.sv
// Directed bench for mux3_1: stimulus pushes hand-computed expectations into a
// queue and a separate monitor pops and compares them against the outputs.
module tb_mux3_1;

  logic       clk;
  logic       rst;
  logic [7:0] d0, d1, d2;
  logic [1:0] s;
  logic       en;
  logic [7:0] y, y_q;
  logic       s_err;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string      name;
    logic [7:0] y_exp;
    logic [7:0] yq_exp;
    logic       serr_exp;
  } exp_t;

  exp_t exp_q[$];
  event chk_ev;

  mux3_1 #(.WIDTH(8)) dut (
    .clk  (clk),
    .rst  (rst),
    .d0   (d0),
    .d1   (d1),
    .d2   (d2),
    .s    (s),
    .en   (en),
    .y    (y),
    .y_q  (y_q),
    .s_err(s_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: each strobe means the outputs are settled and an expectation is queued.
  initial begin
    exp_t e;
    forever begin
      @(chk_ev);
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        total++;
        if (y !== e.y_exp) begin
          bad++;
          $display("FAIL %s.y got=%h want=%h", e.name, y, e.y_exp);
        end
        total++;
        if (y_q !== e.yq_exp) begin
          bad++;
          $display("FAIL %s.y_q got=%h want=%h", e.name, y_q, e.yq_exp);
        end
        total++;
        if (s_err !== e.serr_exp) begin
          bad++;
          $display("FAIL %s.s_err got=%b want=%b", e.name, s_err, e.serr_exp);
        end
        $display("chk %-14s y=%h y_q=%h s_err=%b", e.name, y, y_q, s_err);
      end
    end
  end

  task automatic expect_out(input string name, input logic [7:0] ye,
                            input logic [7:0] yqe, input logic se);
    exp_t e;
    #1;
    e.name = name; e.y_exp = ye; e.yq_exp = yqe; e.serr_exp = se;
    exp_q.push_back(e);
    ->chk_ev;
    #0;
  endtask

  // One rising edge, then return at the falling edge where inputs are driven.
  task automatic edge_cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; s = 2'b00;
    d0 = 8'h54; d1 = 8'h63; d2 = 8'h16;
    #2;
    expect_out("reset", 8'h54, 8'h00, 1'b0);

    @(negedge clk);
    rst = 1'b0;
    expect_out("comb_s00", 8'h54, 8'h00, 1'b0);
    s = 2'b10;
    expect_out("comb_s10", 8'h16, 8'h00, 1'b0);
    s = 2'b01;
    expect_out("comb_s01", 8'h63, 8'h00, 1'b0);
    s = 2'b11;
    expect_out("comb_s11", 8'h00, 8'h00, 1'b0);

    @(negedge clk);
    en = 1'b1; s = 2'b10;
    edge_cycle();
    expect_out("cap_s10", 8'h16, 8'h16, 1'b0);

    en = 1'b0; s = 2'b00;
    repeat (3) edge_cycle();
    expect_out("hold_3", 8'h54, 8'h16, 1'b0);

    en = 1'b1; s = 2'b11;
    edge_cycle();
    expect_out("illegal", 8'h00, 8'h00, 1'b1);

    s = 2'b01;
    edge_cycle();
    expect_out("after_illegal", 8'h63, 8'h63, 1'b0);

    en = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    expect_out("async_rst", 8'h63, 8'h00, 1'b0);
    s = 2'b10;
    expect_out("rst_comb", 8'h16, 8'h00, 1'b0);
    rst = 1'b0; en = 1'b1; s = 2'b00;
    edge_cycle();
    expect_out("post_rst", 8'h54, 8'h54, 1'b0);

    // Unselected inputs must not leak into any output.
    d1 = 8'hff; d2 = 8'haa;
    expect_out("unsel_comb", 8'h54, 8'h54, 1'b0);
    d0 = 8'h0f;
    edge_cycle();
    expect_out("unsel_cap", 8'h0f, 8'h0f, 1'b0);

    s = 2'b11;
    edge_cycle();
    expect_out("illegal_2", 8'h00, 8'h00, 1'b1);
    en = 1'b0;
    edge_cycle();
    expect_out("illegal_noen", 8'h00, 8'h00, 1'b0);

    s = 2'b01;
    en = 1'b1;
    edge_cycle();
    expect_out("cap_d1_ff", 8'hff, 8'hff, 1'b0);

    #1;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain pending=%0d want=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout reached without finishing");
    $fatal(1, "timeout");
  end

endmodule
